// File: rtl/sram_bist.sv
// Two-pass write/read-verify self-test initiator for the async-SRAM bridge.
// Pass 0 writes then verifies (adr[15:0] ^ PATTERN); pass 1 repeats with the
// inverted pattern. The test stops at the first read mismatch.
// Ports:
//   bist_clk, bist_rst      clock, asynchronous active-high reset
//   bist_start_i            start request (ignored while busy)
//   bist_busy_o/done_o      test running / finished (done is sticky)
//   bist_pass_o             result, valid while done=1
//   bist_fail_adr_o/dat_o   first failing address and the data read there
//   sram_*                  request side of the SRAM bridge (stb/ack handshake)
module sram_bist #(
  parameter logic [18:0] LAST_ADR = 19'h7FFFF,
  parameter logic [15:0] PATTERN  = 16'h5A5A
) (
  input  logic        bist_clk,
  input  logic        bist_rst,
  input  logic        bist_start_i,
  output logic        bist_busy_o,
  output logic        bist_done_o,
  output logic        bist_pass_o,
  output logic [18:0] bist_fail_adr_o,
  output logic [15:0] bist_fail_dat_o,
  output logic [18:0] sram_adr_o,
  output logic [15:0] sram_dat_o,
  input  logic [15:0] sram_dat_i,
  output logic        sram_we_o,
  output logic [1:0]  sram_sel_o,
  output logic        sram_stb_o,
  input  logic        sram_ack_i
);

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Expected word; only the low 16 address bits feed the pattern.
  function automatic logic [DW-1:0] expect_dat(input logic [DW-1:0] a, input logic pass);
    return a ^ PATTERN ^ {DW{pass}};
  endfunction

  logic [1:0]    state_q, state_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] adr_d;
  logic [DW-1:0] dat_d;
  logic          we_d, stb_d, busy_d, done_d, pass_o_d;
  logic [AW-1:0] fail_adr_d;
  logic [DW-1:0] fail_dat_d;

  logic          adr_last;
  logic [AW-1:0] adr_inc;
  logic          rd_ok;

  assign adr_last = (sram_adr_o == LAST_ADR);
  assign adr_inc  = AW'(sram_adr_o + AW'(1));
  assign rd_ok    = (sram_dat_i == expect_dat(sram_adr_o[DW-1:0], pass_q));

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    adr_d      = sram_adr_o;
    dat_d      = sram_dat_o;
    we_d       = sram_we_o;
    stb_d      = sram_stb_o;
    busy_d     = bist_busy_o;
    done_d     = bist_done_o;
    pass_o_d   = bist_pass_o;
    fail_adr_d = bist_fail_adr_o;
    fail_dat_d = bist_fail_dat_o;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bist_start_i) begin
          state_d    = S_WR;
          pass_d     = 1'b0;
          adr_d      = '0;
          dat_d      = expect_dat(DW'(0), 1'b0);
          we_d       = 1'b1;
          stb_d      = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_o_d   = 1'b0;
          fail_adr_d = '0;
          fail_dat_d = '0;
        end
      end

      S_WR: begin
        if (sram_ack_i) begin
          if (adr_last) begin
            state_d = S_RD;
            adr_d   = '0;
            we_d    = 1'b0;
            dat_d   = '0;
          end else begin
            adr_d = adr_inc;
            dat_d = expect_dat(adr_inc[DW-1:0], pass_q);
          end
        end
      end

      S_RD: begin
        if (sram_ack_i) begin
          if (!rd_ok || (adr_last && pass_q)) begin
            // Test ends: first mismatch, or clean finish of pass 1.
            state_d  = S_DONE;
            adr_d    = '0;
            stb_d    = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pass_o_d = rd_ok;
            if (!rd_ok) begin
              fail_adr_d = sram_adr_o;
              fail_dat_d = sram_dat_i;
            end
          end else if (!adr_last) begin
            adr_d = adr_inc;
          end else begin
            state_d = S_WR;
            pass_d  = 1'b1;
            adr_d   = '0;
            we_d    = 1'b1;
            dat_d   = expect_dat(DW'(0), 1'b1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset clears everything, dropping stb at once.
  always_ff @(posedge bist_clk or posedge bist_rst) begin
    if (bist_rst) begin
      state_q         <= S_IDLE;
      pass_q          <= 1'b0;
      sram_adr_o      <= '0;
      sram_dat_o      <= '0;
      sram_we_o       <= 1'b0;
      sram_stb_o      <= 1'b0;
      sram_sel_o      <= 2'b00;
      bist_busy_o     <= 1'b0;
      bist_done_o     <= 1'b0;
      bist_pass_o     <= 1'b0;
      bist_fail_adr_o <= '0;
      bist_fail_dat_o <= '0;
    end else begin
      state_q         <= state_d;
      pass_q          <= pass_d;
      sram_adr_o      <= adr_d;
      sram_dat_o      <= dat_d;
      sram_we_o       <= we_d;
      sram_stb_o      <= stb_d;
      sram_sel_o      <= {2{stb_d}};
      bist_busy_o     <= busy_d;
      bist_done_o     <= done_d;
      bist_pass_o     <= pass_o_d;
      bist_fail_adr_o <= fail_adr_d;
      bist_fail_dat_o <= fail_dat_d;
    end
  end

endmodule
